// File: rtl/calc_pkg.sv
// Shared constants for the 3-bit multi-cycle calculator.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the FSM state encodings (4-bit, bit 3 always 0), the opcode values
// and the operand/result width used by calculator_fpga and calc_alu.
package calc_pkg;

  localparam int W = 3;

  // FSM state encodings, exported on CS for LED/debug display
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_ADD    = 4'd3;
  localparam logic [3:0] S_SUB    = 4'd4;
  localparam logic [3:0] S_AND    = 4'd5;
  localparam logic [3:0] S_XOR    = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;

  // opcodes as presented on the op input
  localparam logic [1:0] OP_XOR = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_ADD = 2'd3;

endpackage

// File: rtl/calc_alu.sv
// Combinational 3-bit ALU: XOR / AND / SUB / ADD, results wrap modulo 8.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   a, b : operands (W bits)
//   op   : opcode (OP_XOR/OP_AND/OP_SUB/OP_ADD)
//   y    : result, truncated to W bits
module calc_alu
  import calc_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  // W-bit context gives the modulo-8 wrap for free (e.g. 0-1 = 7)
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/calculator_fpga.sv
// Multi-cycle 3-bit calculator: IDLE->LOAD->DECODE->exec->DONE Moore FSM.
// Latency: go high in IDLE -> done high after exactly 4 posedges.
// Backpressure: none; go is sampled only in IDLE and ignored elsewhere.
//
// Ports:
//   clk  : system clock, all state changes on posedge
//   rst  : asynchronous active-low reset
//   go   : start request (sampled in IDLE)
//   op   : opcode 0=XOR 1=AND 2=SUB 3=ADD
//   in1  : operand A, in2 : operand B (captured on the LOAD edge)
//   CS   : current FSM state encoding
//   done : high while CS==DONE
//   out  : registered result, held outside the execute states
module calculator_fpga
  import calc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [1:0]   op,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [3:0]   CS,
  output logic         done,
  output logic [W-1:0] out
);

  logic [3:0]   cs_q;
  logic [3:0]   cs_nxt;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [1:0]   opr_q;
  logic [W-1:0] out_q;
  logic [W-1:0] alu_y;
  logic         exec;

  calc_alu u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (opr_q),
    .y  (alu_y)
  );

  // state, operand capture and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q  <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      opr_q <= '0;
      out_q <= '0;
    end else begin
      cs_q <= cs_nxt;
      if (cs_q == S_LOAD) begin
        a_q   <= in1;
        b_q   <= in2;
        opr_q <= op;
      end
      if (exec) begin
        out_q <= alu_y;
      end
    end
  end

  // next-state logic; unused encodings fall back to IDLE
  always_comb begin
    cs_nxt = S_IDLE;
    case (cs_q)
      S_IDLE:   cs_nxt = go ? S_LOAD : S_IDLE;
      S_LOAD:   cs_nxt = S_DECODE;
      S_DECODE: begin
        case (opr_q)
          OP_ADD:  cs_nxt = S_ADD;
          OP_SUB:  cs_nxt = S_SUB;
          OP_AND:  cs_nxt = S_AND;
          OP_XOR:  cs_nxt = S_XOR;
          default: cs_nxt = S_IDLE;
        endcase
      end
      S_ADD, S_SUB, S_AND, S_XOR: cs_nxt = S_DONE;
      S_DONE:   cs_nxt = S_IDLE;
      default:  cs_nxt = S_IDLE;
    endcase
  end

  // Moore outputs, decoded from state only
  always_comb begin
    exec = (cs_q == S_ADD) || (cs_q == S_SUB) ||
           (cs_q == S_AND) || (cs_q == S_XOR);
    done = (cs_q == S_DONE);
  end

  assign CS  = cs_q;
  assign out = out_q;

endmodule

// File: tb/tb_calculator_fpga.sv
// Directed + exhaustive bench for calculator_fpga with a result scoreboard.
// Latency: checks the 4-edge go-to-done latency on every run.
// Backpressure: n/a.
module tb_calculator_fpga;

  logic       clk;
  logic       rst;
  logic       go;
  logic [1:0] op;
  logic [2:0] in1;
  logic [2:0] in2;
  logic [3:0] CS;
  logic       done;
  logic [2:0] out;

  int total;
  int bad;
  logic [2:0] sb[$];

  calculator_fpga dut (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .op   (op),
    .in1  (in1),
    .in2  (in2),
    .CS   (CS),
    .done (done),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] model(input logic [2:0] a, input logic [2:0] b,
                                       input logic [1:0] o);
    int r;
    case (o)
      2'd3:    r = (int'(a) + int'(b)) % 8;
      2'd2:    r = (int'(a) - int'(b) + 8) % 8;
      2'd1:    r = int'(a & b);
      default: r = int'(a ^ b);
    endcase
    return r[2:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start an operation from IDLE (called at a negedge); go stays high.
  // With scramble set, operands/opcode are corrupted after the LOAD edge.
  task automatic run_op(input logic [2:0] x, input logic [2:0] y,
                        input logic [1:0] o, input bit scramble);
    int n;
    bit got;
    logic [2:0] e;
    in1 = x;
    in2 = y;
    op  = o;
    go  = 1'b1;
    sb.push_back(model(x, y, o));
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (scramble && n == 2) begin
        in1 = ~x;
        in2 = ~y;
        op  = ~o;
      end
      got = done;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    if (got) begin
      check("latency", n, 32'd4);
      check("cs_done", {28'd0, CS}, 32'd7);
      check("sb_depth", sb.size(), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out", {29'd0, out}, {29'd0, e});
      end
    end else begin
      sb.delete();
    end
  endtask

  // One clock from DONE back to IDLE; result must be held.
  task automatic back_to_idle(input logic [2:0] held);
    @(negedge clk);
    check("idle_cs", {28'd0, CS}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_out_hold", {29'd0, out}, {29'd0, held});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    go    = 1'b0;
    op    = 2'd0;
    in1   = 3'd0;
    in2   = 3'd0;
    #1;
    check("rst_cs", {28'd0, CS}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out", {29'd0, out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // basic ADD, then DONE -> IDLE with result held
    run_op(3'd3, 3'd4, 2'd3, 1'b0);
    go = 1'b0;
    back_to_idle(3'd7);

    // modulo-8 wrap and logic ops
    run_op(3'd5, 3'd6, 2'd3, 1'b0); go = 1'b0; back_to_idle(3'd3);
    run_op(3'd0, 3'd1, 2'd2, 1'b0); go = 1'b0; back_to_idle(3'd7);
    run_op(3'd6, 3'd3, 2'd2, 1'b0); go = 1'b0; back_to_idle(3'd3);
    run_op(3'd6, 3'd3, 2'd1, 1'b0); go = 1'b0; back_to_idle(3'd2);
    run_op(3'd6, 3'd3, 2'd0, 1'b0); go = 1'b0; back_to_idle(3'd5);

    // operands changed after the LOAD edge must not matter
    run_op(3'd2, 3'd5, 2'd2, 1'b1); go = 1'b0; back_to_idle(3'd5);

    // go low: stays in IDLE, result held
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("go_low_cs", {28'd0, CS}, 32'd0);
      check("go_low_out", {29'd0, out}, 32'd5);
    end

    // async reset mid-operation aborts and clears out without a clock edge
    in1 = 3'd7; in2 = 3'd7; op = 2'd3; go = 1'b1;
    @(negedge clk);
    check("pre_rst_load", {28'd0, CS}, 32'd1);
    @(negedge clk);
    check("pre_rst_decode", {28'd0, CS}, 32'd2);
    go = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_cs", {28'd0, CS}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_out", {29'd0, out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_cs", {28'd0, CS}, 32'd0);

    // exhaustive sweep with go held high, one extra clock between runs
    for (int o = 0; o < 4; o++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          run_op(a[2:0], b[2:0], o[1:0], 1'b0);
          @(negedge clk);
          check("sweep_idle", {28'd0, CS}, 32'd0);
        end
      end
    end
    go = 1'b0;

    check("sb_empty_end", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
